skin_bbox_detect: RTL and testbench
===================================

// Module: skin_bbox_detect
// PURPOSE
//  Pixel-stream stage directly downstream of RAW2RGB, in the D5M pixel-clock domain; taps the same RGB stream that feeds the SDRAM write FIFOs.
//  Classifies each pixel as skin via fixed-point Cb/Cr thresholds and emits a delayed RGB+mask stream for overlay.
//  Accumulates a per-frame bounding box and skin-pixel count, offered to proc through a valid/ack handshake.
// PARAMETERS
//  IMG_W       640  active pixels per line (x wraps here)
//  IMG_H       480  active lines per frame (y saturates at IMG_H-1)
//  CB_MIN/MAX  77/127   inclusive Cb skin window (8-bit)
//  CR_MIN/MAX  133/173  inclusive Cr skin window (8-bit)
//  MIN_PIXELS  256  minimum skin count for o_bb_found=1
// PORTS
//  clk          in   1   pixel clock; all logic on rising edge
//  rst          in   1   synchronous, active-high reset
//  i_r,i_g,i_b  in   12  RGB from RAW2RGB; only [11:4] are used
//  i_dval       in   1   pixel valid
//  i_fval       in   1   frame valid, registered from the sensor
//  o_r,o_g,o_b  out  12  RGB delayed 3 cycles, unmodified
//  o_dval       out  1   i_dval delayed 3 cycles
//  o_mask       out  1   skin flag, aligned with o_dval
//  o_bb_xmin/xmax out 10  bounding-box columns
//  o_bb_ymin/ymax out 9   bounding-box rows
//  o_bb_count   out  19  skin pixels in the frame
//  o_bb_found   out  1   o_bb_count >= MIN_PIXELS
//  o_bb_valid   out  1   result available; held until acked
//  o_bb_overrun out  1   sticky: an unacked result was overwritten
//  i_bb_ack     in   1   consumer takes the result (one-cycle pulse)
// BEHAVIOUR
//  Reset: every output 0; FSM=IDLE; x/y=0; partial frame discarded.
//  Coordinates: x,y are counted at the input on i_dval and piped with the data.
//   - x==IMG_W-1 -> x=0, y++.
//   - y saturates; pixels past IMG_H*IMG_W update no stats.
//  Pipeline (3 cycles, no stalls):
//   - S1: Cb' = -43R - 85G + 128B; Cr' = 128R - 107G - 21B (signed 18b).
//   - S2: Cb = 128 + (Cb'>>>8), Cr = 128 + (Cr'>>>8), arithmetic shift, clamp to 0..255; window compare.
//   - S3: register outputs.
//   - o_mask=0 whenever o_dval=0.
//  FSM: IDLE -> ACTIVE -> DRAIN -> PUBLISH -> IDLE.
//   - IDLE: wait for a rising edge of i_fval (fval high on reset exit = missed edge; wait for the next one).
//   - Entering ACTIVE clears x, y and stats: xmin=IMG_W-1, ymin=IMG_H-1, xmax=ymax=count=0.
//   - ACTIVE: each S3 pixel with mask=1 updates min/max/count. Falling edge of i_fval -> DRAIN.
//   - DRAIN: 3 cycles; pipeline still updates stats; i_fval is ignored.
//   - PUBLISH: one cycle; latch stats into o_bb_*, set o_bb_valid=1.
//   - count=0 -> box outputs = cleared values and found=0.
//  Handshake:
//   - i_bb_ack with valid=1 clears valid and overrun next cycle.
//   - i_bb_ack with valid=0 is ignored.
//   - PUBLISH with valid=1 and no ack: overwrite the result, set overrun.
//   - PUBLISH and ack in the same cycle: new result latched, valid stays 1, overrun cleared.
//  o_bb_* are stable whenever o_bb_valid=1, except on a PUBLISH overwrite.
// STRUCTURE
//  face_filter_pkg: IMG_W/IMG_H, Cb/Cr coefficients, default thresholds, FSM state encoding, PIPE_LAT=3.
//  Sub-module rgb2cbcr_skin: S1/S2 arithmetic and window compare, 2-cycle latency.
//  Top level holds the coordinate counters, FSM, stats, result registers and handshake.
// TESTING
//  1. 640x480 frame; skin pixel RGB(200,140,110) at x=100..199, y=50..149, rest (0,0,255)
//     -> xmin=100, xmax=199, ymin=50, ymax=149, count=10000, found=1, valid=1.
//  2. Same frame, o_mask traced -> rises exactly 3 cycles after the first skin input beat; o_r/o_g/o_b bit-exact.
//  3. All-blue frame -> count=0, found=0, xmin=639, ymin=479, xmax=ymax=0, valid=1.
//  4. Two frames with no ack -> overrun=1, second frame's box present.
//     Ack in the PUBLISH cycle of frame 3 -> valid=1, overrun=0.
//  5. rst asserted mid-frame -> outputs 0 next cycle; remainder of frame ignored; next full frame reports correctly.
//  6. Edges: skin only at x=639,y=479 -> box 639/639/479/479, count=1, found=0.
//     Extra line beyond 480 -> no stats change.

Source files
------------

// File: rtl/skin_bbox_detect_pkg.sv
// Shared constants, FSM encoding and helpers for the skin bounding-box detector.
`timescale 1ns/1ps
package skin_bbox_detect_pkg;
    localparam int IMG_W      = 640;
    localparam int IMG_H      = 480;
    localparam int MIN_PIXELS = 256;
    localparam int PIPE_LAT   = 3;

    localparam logic [7:0] CB_MIN = 8'd77;
    localparam logic [7:0] CB_MAX = 8'd127;
    localparam logic [7:0] CR_MIN = 8'd133;
    localparam logic [7:0] CR_MAX = 8'd173;

    localparam logic signed [17:0] CB_KR = -18'sd43;
    localparam logic signed [17:0] CB_KG = -18'sd85;
    localparam logic signed [17:0] CB_KB = 18'sd128;
    localparam logic signed [17:0] CR_KR = 18'sd128;
    localparam logic signed [17:0] CR_KG = -18'sd107;
    localparam logic signed [17:0] CR_KB = -18'sd21;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DRAIN,
        ST_PUBLISH
    } bbox_state_e;

    function automatic logic [7:0] clamp_u8(input logic signed [17:0] v);
        if (v < 18'sd0)
            return 8'd0;
        else if (v > 18'sd255)
            return 8'hff;
        else
            return v[7:0];
    endfunction
endpackage

// File: rtl/skin_bbox_detect_if.sv
// Pixel stream in/out plus the per-frame result handshake of the skin detector.
`timescale 1ns/1ps
interface skin_bbox_detect_if;
    logic [11:0] i_r, i_g, i_b;
    logic        i_dval;
    logic        i_fval;
    logic [11:0] o_r, o_g, o_b;
    logic        o_dval;
    logic        o_mask;
    logic [9:0]  o_bb_xmin, o_bb_xmax;
    logic [8:0]  o_bb_ymin, o_bb_ymax;
    logic [18:0] o_bb_count;
    logic        o_bb_found;
    logic        o_bb_valid;
    logic        o_bb_overrun;
    logic        i_bb_ack;

    modport master (
        output i_r, i_g, i_b, i_dval, i_fval, i_bb_ack,
        input  o_r, o_g, o_b, o_dval, o_mask,
        input  o_bb_xmin, o_bb_xmax, o_bb_ymin, o_bb_ymax,
        input  o_bb_count, o_bb_found, o_bb_valid, o_bb_overrun
    );

    modport slave (
        input  i_r, i_g, i_b, i_dval, i_fval, i_bb_ack,
        output o_r, o_g, o_b, o_dval, o_mask,
        output o_bb_xmin, o_bb_xmax, o_bb_ymin, o_bb_ymax,
        output o_bb_count, o_bb_found, o_bb_valid, o_bb_overrun
    );
endinterface

// File: rtl/skin_bbox_detect_rgb2cbcr_skin.sv
// RGB to Cb/Cr conversion and skin window compare; skin_o lags the input by 2 cycles.
`timescale 1ns/1ps
module rgb2cbcr_skin
    import skin_bbox_detect_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] r_i,
    input  logic [7:0] g_i,
    input  logic [7:0] b_i,
    input  logic       dval_i,
    output logic       skin_o
);
    logic signed [17:0] r_s, g_s, b_s;
    logic signed [17:0] cbp_d, crp_d, cbp_q, crp_q;
    logic signed [17:0] cb_full, cr_full;
    logic [7:0]         cb, cr;
    logic               dval_q, skin_d;

    always_comb begin
        r_s   = $signed({10'd0, r_i});
        g_s   = $signed({10'd0, g_i});
        b_s   = $signed({10'd0, b_i});
        cbp_d = CB_KR * r_s + CB_KG * g_s + CB_KB * b_s;
        crp_d = CR_KR * r_s + CR_KG * g_s + CR_KB * b_s;
    end

    // Arithmetic shift floors negative values; the clamp is a guard for the extremes.
    always_comb begin
        cb_full = 18'sd128 + (cbp_q >>> 8);
        cr_full = 18'sd128 + (crp_q >>> 8);
        cb      = clamp_u8(cb_full);
        cr      = clamp_u8(cr_full);
        skin_d  = dval_q && (cb >= CB_MIN) && (cb <= CB_MAX)
                         && (cr >= CR_MIN) && (cr <= CR_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cbp_q  <= '0;
            crp_q  <= '0;
            dval_q <= 1'b0;
            skin_o <= 1'b0;
        end else begin
            cbp_q  <= cbp_d;
            crp_q  <= crp_d;
            dval_q <= dval_i;
            skin_o <= skin_d;
        end
    end
endmodule

// File: rtl/skin_bbox_detect.sv
// Skin-pixel classifier with delayed RGB+mask stream and per-frame bounding-box result.
// state      | meaning
// ST_IDLE    | waiting for a rising edge of i_fval
// ST_ACTIVE  | frame in progress, stats accumulate
// ST_DRAIN   | PIPE_LAT cycles letting the pipeline tail reach the stats
// ST_PUBLISH | latch stats into the result registers
`timescale 1ns/1ps
module skin_bbox_detect
    import skin_bbox_detect_pkg::*;
#(
    parameter int P_IMG_W      = IMG_W,
    parameter int P_IMG_H      = IMG_H,
    parameter int P_MIN_PIXELS = MIN_PIXELS
) (
    input  logic                clk,
    input  logic                rst,
    skin_bbox_detect_if.slave   bus
);
    localparam logic [9:0]  X_LAST = 10'(P_IMG_W - 1);
    localparam logic [8:0]  Y_LAST = 9'(P_IMG_H - 1);
    localparam logic [18:0] MIN_CNT = 19'(P_MIN_PIXELS);

    logic [9:0]  x_q;
    logic [8:0]  y_q;
    logic        past_end_q;
    logic        fval_q, fval_rise, fval_fall, enter_active;
    bbox_state_e state_q;
    logic [1:0]  drain_q;

    logic [35:0] rgb1_q, rgb2_q, rgb3_q;
    logic        dval1_q, dval2_q, dval3_q, mask3_q, skin_w;
    logic [9:0]  x1_q, x2_q, x3_q;
    logic [8:0]  y1_q, y2_q, y3_q;
    logic        inr1_q, inr2_q, inr3_q, stat_hit;

    logic [9:0]  xmin_q, xmax_q, bb_xmin_q, bb_xmax_q;
    logic [8:0]  ymin_q, ymax_q, bb_ymin_q, bb_ymax_q;
    logic [18:0] cnt_q, bb_count_q;
    logic        bb_found_q, bb_valid_q, bb_overrun_q;

    assign fval_rise    = bus.i_fval & ~fval_q;
    assign fval_fall    = ~bus.i_fval & fval_q;
    assign enter_active = (state_q == ST_IDLE) & fval_rise;
    assign stat_hit     = mask3_q & inr3_q;

    rgb2cbcr_skin u_cbcr (
        .clk    (clk),
        .rst    (rst),
        .r_i    (bus.i_r[11:4]),
        .g_i    (bus.i_g[11:4]),
        .b_i    (bus.i_b[11:4]),
        .dval_i (bus.i_dval),
        .skin_o (skin_w)
    );

    // past_end_q marks pixels beyond the last active one so they never touch the stats.
    always_ff @(posedge clk) begin
        if (rst || enter_active) begin
            x_q        <= '0;
            y_q        <= '0;
            past_end_q <= 1'b0;
        end else if (bus.i_dval) begin
            if (x_q == X_LAST) begin
                x_q <= '0;
                if (y_q == Y_LAST)
                    past_end_q <= 1'b1;
                else
                    y_q <= y_q + 9'd1;
            end else begin
                x_q <= x_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {rgb1_q, rgb2_q, rgb3_q}    <= '0;
            {dval1_q, dval2_q, dval3_q} <= '0;
            {x1_q, x2_q, x3_q}          <= '0;
            {y1_q, y2_q, y3_q}          <= '0;
            {inr1_q, inr2_q, inr3_q}    <= '0;
            mask3_q                     <= 1'b0;
        end else begin
            rgb1_q  <= {bus.i_r, bus.i_g, bus.i_b};
            dval1_q <= bus.i_dval;
            x1_q    <= x_q;
            y1_q    <= y_q;
            inr1_q  <= ~past_end_q;
            rgb2_q  <= rgb1_q;
            dval2_q <= dval1_q;
            x2_q    <= x1_q;
            y2_q    <= y1_q;
            inr2_q  <= inr1_q;
            rgb3_q  <= rgb2_q;
            dval3_q <= dval2_q;
            x3_q    <= x2_q;
            y3_q    <= y2_q;
            inr3_q  <= inr2_q;
            mask3_q <= skin_w;
        end
    end

    // fval_q resets high so a frame already in progress at reset exit is skipped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            fval_q       <= 1'b1;
            drain_q      <= '0;
            {xmin_q, xmax_q, ymin_q, ymax_q, cnt_q} <= '0;
            {bb_xmin_q, bb_xmax_q, bb_ymin_q, bb_ymax_q, bb_count_q} <= '0;
            {bb_found_q, bb_valid_q, bb_overrun_q} <= '0;
        end else begin
            fval_q <= bus.i_fval;
            if ((state_q == ST_ACTIVE || state_q == ST_DRAIN) && stat_hit) begin
                if (x3_q < xmin_q) xmin_q <= x3_q;
                if (x3_q > xmax_q) xmax_q <= x3_q;
                if (y3_q < ymin_q) ymin_q <= y3_q;
                if (y3_q > ymax_q) ymax_q <= y3_q;
                cnt_q <= cnt_q + 19'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (fval_rise) begin
                        state_q <= ST_ACTIVE;
                        xmin_q  <= X_LAST;
                        ymin_q  <= Y_LAST;
                        xmax_q  <= '0;
                        ymax_q  <= '0;
                        cnt_q   <= '0;
                    end
                end
                ST_ACTIVE: begin
                    if (fval_fall) begin
                        state_q <= ST_DRAIN;
                        drain_q <= 2'(PIPE_LAT - 1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == 2'd0)
                        state_q <= ST_PUBLISH;
                    else
                        drain_q <= drain_q - 2'd1;
                end
                ST_PUBLISH: state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
            if (state_q == ST_PUBLISH) begin
                bb_xmin_q    <= xmin_q;
                bb_xmax_q    <= xmax_q;
                bb_ymin_q    <= ymin_q;
                bb_ymax_q    <= ymax_q;
                bb_count_q   <= cnt_q;
                bb_found_q   <= (cnt_q >= MIN_CNT);
                bb_valid_q   <= 1'b1;
                bb_overrun_q <= bb_valid_q & ~bus.i_bb_ack;
            end else if (bus.i_bb_ack && bb_valid_q) begin
                bb_valid_q   <= 1'b0;
                bb_overrun_q <= 1'b0;
            end
        end
    end

    assign bus.o_r          = rgb3_q[35:24];
    assign bus.o_g          = rgb3_q[23:12];
    assign bus.o_b          = rgb3_q[11:0];
    assign bus.o_dval       = dval3_q;
    assign bus.o_mask       = mask3_q;
    assign bus.o_bb_xmin    = bb_xmin_q;
    assign bus.o_bb_xmax    = bb_xmax_q;
    assign bus.o_bb_ymin    = bb_ymin_q;
    assign bus.o_bb_ymax    = bb_ymax_q;
    assign bus.o_bb_count   = bb_count_q;
    assign bus.o_bb_found   = bb_found_q;
    assign bus.o_bb_valid   = bb_valid_q;
    assign bus.o_bb_overrun = bb_overrun_q;
endmodule

// File: tb/tb_skin_bbox_detect.sv
// Scoreboard bench for skin_bbox_detect on a reduced 32x24 frame.
`timescale 1ns/1ps
module tb_skin_bbox_detect;
    localparam int W    = 32;
    localparam int H    = 24;
    localparam int MINP = 64;

    typedef struct {
        logic [35:0] rgb;
        logic        mask;
        int unsigned cyc;
    } pix_t;

    typedef struct {
        logic [9:0]  xmin, xmax;
        logic [8:0]  ymin, ymax;
        logic [18:0] count;
        logic        found, overrun;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int unsigned cyc = 0;
    pix_t pixq[$];
    res_t resq[$];
    logic [23:0] skin_c [3];
    logic [23:0] bg_c   [3];
    logic        pv = 1'b0;
    logic [57:0] pf = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    skin_bbox_detect_if bus();

    skin_bbox_detect #(.P_IMG_W(W), .P_IMG_H(H), .P_MIN_PIXELS(MINP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic res_t mk_res(int xmin, int xmax, int ymin, int ymax, int count, int found, int ov);
        res_t r;
        r.xmin    = 10'(xmin);
        r.xmax    = 10'(xmax);
        r.ymin    = 9'(ymin);
        r.ymax    = 9'(ymax);
        r.count   = 19'(count);
        r.found   = 1'(found);
        r.overrun = 1'(ov);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rgb"},  {bus.o_r, bus.o_g, bus.o_b}, 64'd0);
        check({tag, "_dval"}, {bus.o_dval, bus.o_mask}, 64'd0);
        check({tag, "_box"},  {bus.o_bb_xmin, bus.o_bb_xmax, bus.o_bb_ymin, bus.o_bb_ymax}, 64'd0);
        check({tag, "_cnt"},  bus.o_bb_count, 64'd0);
        check({tag, "_flags"}, {bus.o_bb_found, bus.o_bb_valid, bus.o_bb_overrun}, 64'd0);
    endtask

    // Monitor: pixel stream against pixq, new results against resq.
    always @(negedge clk) begin
        pix_t e;
        res_t r;
        logic [57:0] cur;
        cur = {bus.o_bb_xmin, bus.o_bb_xmax, bus.o_bb_ymin, bus.o_bb_ymax, bus.o_bb_count, bus.o_bb_found};
        if (!rst) begin
            if (bus.o_dval) begin
                if (pixq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pix_unexpected: o_dval=1 with nothing expected (cycle %0d)", cyc);
                end else begin
                    e = pixq.pop_front();
                    check("pix_rgb", {bus.o_r, bus.o_g, bus.o_b}, e.rgb);
                    check("pix_mask", bus.o_mask, e.mask);
                    check("pix_latency", cyc - e.cyc, 64'd3);
                end
            end else begin
                check("mask_idle", bus.o_mask, 64'd0);
            end
            if (bus.o_bb_valid && (!pv || cur != pf)) begin
                if (resq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL res_unexpected: result count=%0d with nothing expected", bus.o_bb_count);
                end else begin
                    r = resq.pop_front();
                    check("res_xmin", bus.o_bb_xmin, r.xmin);
                    check("res_xmax", bus.o_bb_xmax, r.xmax);
                    check("res_ymin", bus.o_bb_ymin, r.ymin);
                    check("res_ymax", bus.o_bb_ymax, r.ymax);
                    check("res_count", bus.o_bb_count, r.count);
                    check("res_found", bus.o_bb_found, r.found);
                    check("res_overrun", bus.o_bb_overrun, r.overrun);
                end
            end
        end
        pv = bus.o_bb_valid;
        pf = cur;
    end

    task automatic reset_mid();
        rst = 1'b1;
        bus.i_dval = 1'b0;
        step();
        pixq.delete();
        @(negedge clk);
        check_all_zero("rst_mid");
        step();
        rst = 1'b0;
    endtask

    // ack_mode 1: ack lands in the PUBLISH cycle (3 DRAIN cycles after the fval fall is seen).
    task automatic drive_frame(input int x0, input int x1, input int y0, input int y1,
                               input bit extra, input int rst_line, input int ack_mode,
                               input int old_count, input res_t exp, input bit push);
        logic [23:0] c;
        logic        m;
        bit          ins;
        bus.i_fval = 1'b1;
        repeat (3) step();
        for (int y = 0; y < H + (extra ? 1 : 0); y++) begin
            if (y == rst_line) reset_mid();
            for (int x = 0; x < W; x++) begin
                ins = (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
                if (ins || y >= H) begin
                    c = skin_c[(x + y) % 3];
                    m = 1'b1;
                end else begin
                    c = bg_c[(x + y) % 3];
                    m = 1'b0;
                end
                bus.i_r    = {c[23:16], 4'(x)};
                bus.i_g    = {c[15:8], 4'(y)};
                bus.i_b    = {c[7:0], 4'hA};
                bus.i_dval = 1'b1;
                pixq.push_back('{rgb: {bus.i_r, bus.i_g, bus.i_b}, mask: m, cyc: cyc});
                step();
            end
            bus.i_dval = 1'b0;
            repeat (3) step();
        end
        if (push) resq.push_back(exp);
        bus.i_fval = 1'b0;
        if (ack_mode == 1) begin
            repeat (4) step();
            bus.i_bb_ack = 1'b1;
            @(negedge clk);
            check("pre_publish_valid", {bus.o_bb_valid, bus.o_bb_overrun}, 64'h3);
            check("pre_publish_count", bus.o_bb_count, 64'(old_count));
            step();
            bus.i_bb_ack = 1'b0;
            @(negedge clk);
            check("ackpub_valid", {bus.o_bb_valid, bus.o_bb_overrun}, 64'h2);
            check("ackpub_count", bus.o_bb_count, exp.count);
            step();
        end
        repeat (10) step();
    endtask

    task automatic ack_result();
        for (int i = 0; i < 40 && !bus.o_bb_valid; i++) step();
        check("valid_seen", bus.o_bb_valid, 64'd1);
        bus.i_bb_ack = 1'b1;
        step();
        bus.i_bb_ack = 1'b0;
        @(negedge clk);
        check("after_ack", {bus.o_bb_valid, bus.o_bb_overrun}, 64'd0);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // (200,140,110) Cb=102 Cr=160; (226,140,110) Cr=173; (200,140,59) Cb=77
        skin_c[0] = 24'hC88C6E;
        skin_c[1] = 24'hE28C6E;
        skin_c[2] = 24'hC88C3B;
        // (0,0,255) Cb=255; (228,140,110) Cr=174; (200,140,58) Cb=76
        bg_c[0]   = 24'h0000FF;
        bg_c[1]   = 24'hE48C6E;
        bg_c[2]   = 24'hC88C3A;
        bus.i_r = '0;
        bus.i_g = '0;
        bus.i_b = '0;
        bus.i_dval = 1'b0;
        bus.i_fval = 1'b0;
        bus.i_bb_ack = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check_all_zero("reset");
        step();
        rst = 1'b0;
        repeat (3) step();

        drive_frame(10, 19, 5, 14, 1'b0, -1, 0, 0, mk_res(10, 19, 5, 14, 100, 1, 0), 1'b1);
        ack_result();
        drive_frame(1, 0, 0, -1, 1'b0, -1, 0, 0, mk_res(31, 0, 23, 0, 0, 0, 0), 1'b1);
        ack_result();

        drive_frame(0, 3, 0, 3, 1'b0, -1, 0, 0, mk_res(0, 3, 0, 3, 16, 0, 0), 1'b1);
        drive_frame(20, 31, 10, 17, 1'b0, -1, 0, 0, mk_res(20, 31, 10, 17, 96, 1, 1), 1'b1);
        drive_frame(5, 12, 20, 23, 1'b0, -1, 1, 96, mk_res(5, 12, 20, 23, 32, 0, 0), 1'b1);
        ack_result();
        bus.i_bb_ack = 1'b1;
        step();
        bus.i_bb_ack = 1'b0;
        @(negedge clk);
        check("ack_ignored", {bus.o_bb_valid, bus.o_bb_overrun}, 64'd0);
        check("ack_ignored_count", bus.o_bb_count, 64'd32);
        step();

        drive_frame(0, 31, 0, 23, 1'b0, 5, 0, 0, mk_res(0, 0, 0, 0, 0, 0, 0), 1'b0);
        check("rst_frame_no_result", bus.o_bb_valid, 64'd0);
        drive_frame(2, 30, 1, 22, 1'b0, -1, 0, 0, mk_res(2, 30, 1, 22, 638, 1, 0), 1'b1);
        ack_result();

        drive_frame(31, 31, 23, 23, 1'b1, -1, 0, 0, mk_res(31, 31, 23, 23, 1, 0, 0), 1'b1);
        ack_result();

        repeat (10) step();
        check("pixq_drained", pixq.size(), 64'd0);
        check("resq_drained", resq.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
